// File: rtl/transmissao_pkg.sv
// transmissao_pkg: FSM state codes and default frame constants for the serial matrix transmitter
package transmissao_pkg;
  typedef enum logic [3:0] {
    ST_INICIAL    = 4'd0,
    ST_CABECALHO  = 4'd1,
    ST_LE_MEM     = 4'd2,
    ST_CARREGA    = 4'd3,
    ST_ENVIA      = 4'd4,
    ST_ESPERA     = 4'd5,
    ST_PROXIMO    = 4'd6,
    ST_RODAPE     = 4'd7,
    ST_ESPERA_FIM = 4'd8,
    ST_FIM        = 4'd9
  } estado_t;
  localparam logic [7:0] CABECALHO_PADRAO = 8'h02;
  localparam logic [7:0] RODAPE_PADRAO    = 8'h03;
endpackage

// File: rtl/contador_m.sv
// contador_m: modulo-M counter with async active-low reset, sync clear and end-of-count flag
module contador_m #(
  parameter int M = 3,
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] q,
  output logic         fim
);
  assign fim = q == N'(M - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) q <= '0;
    else if (zera) q <= '0;
    else if (conta) q <= fim ? '0 : q + N'(1);
endmodule

// File: rtl/transmissao_matriz_serial.sv
// transmissao_matriz_serial: streams a LINES x COLUMNS word memory row-major, MSB byte first, to a UART
module transmissao_matriz_serial
  import transmissao_pkg::*;
#(
  parameter int         LINES       = 3,
  parameter int         COLUMNS     = 3,
  parameter int         S_DATA      = 16,
  parameter int         S_LINE      = 2,
  parameter int         S_COLUMN    = 2,
  parameter int         COM_MOLDURA = 0,
  parameter logic [7:0] CABECALHO   = CABECALHO_PADRAO,
  parameter logic [7:0] RODAPE      = RODAPE_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                partida,
  output logic [S_LINE-1:0]   addr_linha,
  output logic [S_COLUMN-1:0] addr_coluna,
  input  logic [S_DATA-1:0]   dados_mem,
  output logic [7:0]          tx_dados,
  output logic                tx_partida,
  input  logic                tx_pronto,
  output logic                ocupado,
  output logic                pronto,
  output logic [3:0]          db_estado
);
  localparam int B = S_DATA / 8;
  localparam logic [2:0] ULT = 3'(B - 1);
  estado_t estado, prox;
  logic [S_DATA-1:0] palavra, desloc;
  logic [2:0] indice;
  logic [7:0] tx_reg, byte_atual;
  logic apos_cab, zera_cont, conta_col, conta_lin, fim_col, fim_lin;
  contador_m #(.M(COLUMNS), .N(S_COLUMN)) u_coluna (
    .clock(clock), .reset(reset), .zera(zera_cont), .conta(conta_col), .q(addr_coluna), .fim(fim_col)
  );
  contador_m #(.M(LINES), .N(S_LINE)) u_linha (
    .clock(clock), .reset(reset), .zera(zera_cont), .conta(conta_lin), .q(addr_linha), .fim(fim_lin)
  );
  assign desloc     = palavra >> {ULT - indice, 3'b000};
  assign byte_atual = estado == ST_CABECALHO ? CABECALHO : estado == ST_RODAPE ? RODAPE : desloc[7:0];
  assign tx_partida = estado == ST_CABECALHO || estado == ST_ENVIA || estado == ST_RODAPE;
  // the byte is live while its start pulse is out, then held from the register until tx_pronto
  assign tx_dados   = tx_partida ? byte_atual : tx_reg;
  assign ocupado    = estado != ST_INICIAL;
  assign pronto     = estado == ST_FIM;
  assign db_estado  = estado;
  always_comb begin
    prox      = estado;
    zera_cont = 1'b0;
    conta_col = 1'b0;
    conta_lin = 1'b0;
    case (estado)
      ST_INICIAL: if (partida) begin
        zera_cont = 1'b1;
        prox      = COM_MOLDURA != 0 ? ST_CABECALHO : ST_LE_MEM;
      end
      ST_CABECALHO:  prox = ST_ESPERA;
      ST_LE_MEM:     prox = ST_CARREGA;
      ST_CARREGA:    prox = ST_ENVIA;
      ST_ENVIA:      prox = ST_ESPERA;
      ST_ESPERA:     if (tx_pronto) prox = apos_cab ? ST_LE_MEM : indice == ULT ? ST_PROXIMO : ST_ENVIA;
      ST_PROXIMO: if (fim_col && fim_lin) prox = COM_MOLDURA != 0 ? ST_RODAPE : ST_FIM;
      else begin
        conta_col = 1'b1;
        conta_lin = fim_col;
        prox      = ST_LE_MEM;
      end
      ST_RODAPE:     prox = ST_ESPERA_FIM;
      ST_ESPERA_FIM: if (tx_pronto) prox = ST_FIM;
      ST_FIM:        prox = ST_INICIAL;
      default:       prox = ST_INICIAL;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado   <= ST_INICIAL;
      palavra  <= '0;
      indice   <= '0;
      tx_reg   <= '0;
      apos_cab <= 1'b0;
    end else begin
      estado <= prox;
      if (estado == ST_CARREGA) begin
        palavra <= dados_mem;
        indice  <= '0;
      end
      if (estado == ST_ESPERA && tx_pronto && !apos_cab && indice != ULT) indice <= indice + 3'd1;
      if (tx_partida) tx_reg <= byte_atual;
      if (estado == ST_CABECALHO) apos_cab <= 1'b1;
      else if (estado == ST_LE_MEM) apos_cab <= 1'b0;
    end
endmodule

// File: tb/tb_transmissao_matriz_serial.sv
// tb_transmissao_matriz_serial: three configurations driven by a memory/UART model and checked against a frame model
module tb_transmissao_matriz_serial;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;
  logic [2:0] partida = '0, stray = '0, resp = '0, tx_pronto, txp, ocup, pr;
  logic [1:0] al [3], ac [3];
  logic [7:0] txd [3];
  logic [3:0] est [3];
  logic [23:0] dm [3];
  logic [23:0] mem [3][9];
  logic [7:0] got [$], held [$], exp_q [$];
  int cnt [3], lat [3];
  int n_pronto = 0, n_cmp = 0, n_fail = 0;
  assign tx_pronto = resp | stray;
  transmissao_matriz_serial u0 (
    .clock(clk), .reset(reset_n), .partida(partida[0]), .addr_linha(al[0]), .addr_coluna(ac[0]),
    .dados_mem(dm[0][15:0]), .tx_dados(txd[0]), .tx_partida(txp[0]), .tx_pronto(tx_pronto[0]),
    .ocupado(ocup[0]), .pronto(pr[0]), .db_estado(est[0]));
  transmissao_matriz_serial #(.COM_MOLDURA(1)) u1 (
    .clock(clk), .reset(reset_n), .partida(partida[1]), .addr_linha(al[1]), .addr_coluna(ac[1]),
    .dados_mem(dm[1][15:0]), .tx_dados(txd[1]), .tx_partida(txp[1]), .tx_pronto(tx_pronto[1]),
    .ocupado(ocup[1]), .pronto(pr[1]), .db_estado(est[1]));
  transmissao_matriz_serial #(.S_DATA(24), .LINES(2), .COLUMNS(2)) u2 (
    .clock(clk), .reset(reset_n), .partida(partida[2]), .addr_linha(al[2]), .addr_coluna(ac[2]),
    .dados_mem(dm[2]), .tx_dados(txd[2]), .tx_partida(txp[2]), .tx_pronto(tx_pronto[2]),
    .ocupado(ocup[2]), .pronto(pr[2]), .db_estado(est[2]));
  function automatic int n_lin(int d); return d == 2 ? 2 : 3; endfunction
  function automatic int n_col(int d); return d == 2 ? 2 : 3; endfunction
  function automatic int n_byt(int d); return d == 2 ? 3 : 2; endfunction
  always @(posedge clk)
    for (int i = 0; i < 3; i++) dm[i] <= mem[i][int'(al[i]) * n_col(i) + int'(ac[i])];
  // UART model: acknowledges each start pulse lat cycles later, recording the byte sent and the byte held
  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      resp[i] = 1'b0;
      if (!reset_n) cnt[i] = 0;
      else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          resp[i] = 1'b1;
          held.push_back(txd[i]);
        end
      end
      if (txp[i]) begin
        got.push_back(txd[i]);
        cnt[i] = lat[i];
      end
      if (pr[i]) n_pronto++;
    end
  function automatic void build_exp(int d);
    exp_q.delete();
    if (d == 1) exp_q.push_back(8'h02);
    for (int k = 0; k < n_lin(d) * n_col(d); k++)
      for (int b = n_byt(d) - 1; b >= 0; b--) exp_q.push_back(8'(mem[d][k] >> (8 * b)));
    if (d == 1) exp_q.push_back(8'h03);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  task automatic fill(input int d, input bit rnd);
    for (int k = 0; k < 9; k++)
      mem[d][k] = rnd ? 24'($urandom) : d == 2 ? 24'h112233 : 24'(16'h0A0B + k);
  endtask
  task automatic pulse_partida(input int d);
    #1 partida[d] = 1'b1;
    @(negedge clk);
    #1 partida[d] = 1'b0;
  endtask
  task automatic run_frame(input int d, input int l, input bit extra, input int nb, input string nm);
    int bg, bh, bp;
    lat[d] = l;
    bg = got.size();
    bh = held.size();
    bp = n_pronto;
    @(negedge clk);
    pulse_partida(d);
    if (extra) begin
      for (int t = 0; t < 5000 && got.size() < bg + 3; t++) @(negedge clk);
      pulse_partida(d);
    end
    for (int t = 0; t < 20000 && n_pronto == bp; t++) @(negedge clk);
    repeat (40) @(negedge clk);
    build_exp(d);
    chk({nm, " nbytes"}, got.size() - bg, nb);
    chk({nm, " nbytes_model"}, got.size() - bg, exp_q.size());
    for (int i = 0; i < exp_q.size() && bg + i < got.size(); i++)
      chk($sformatf("%s byte%0d", nm, i), got[bg + i], exp_q[i]);
    for (int i = 0; i < exp_q.size() && bh + i < held.size(); i++)
      chk($sformatf("%s held%0d", nm, i), held[bh + i], exp_q[i]);
    chk({nm, " pronto_pulses"}, n_pronto - bp, 1);
    chk({nm, " ocupado_end"}, ocup[d], 0);
    chk({nm, " estado_end"}, est[d], 0);
  endtask
  typedef struct {int d; int lat; bit rnd; int nbytes;} vec_t;
  vec_t tab [8];
  initial begin
    int bg;
    tab[0] = '{0, 20, 1'b0, 18};
    tab[1] = '{1, 20, 1'b0, 20};
    tab[2] = '{2, 20, 1'b0, 12};
    tab[3] = '{0, 1, 1'b0, 18};
    tab[4] = '{1, 1, 1'b1, 20};
    tab[5] = '{2, 1, 1'b1, 12};
    tab[6] = '{0, 3, 1'b1, 18};
    tab[7] = '{2, 2, 1'b0, 12};
    for (int i = 0; i < 3; i++) begin
      fill(i, 1'b0);
      lat[i] = 20;
    end
    reset_n = 1'b0;
    #12;
    chk("rst tx_dados", txd[0], 0);
    chk("rst tx_partida", txp, 0);
    chk("rst ocupado", ocup, 0);
    chk("rst pronto", pr, 0);
    chk("rst addr", {al[0], ac[0]}, 0);
    chk("rst estado", est[0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 stray[0] = 1'b1;
    @(negedge clk);
    #1 stray[0] = 1'b0;
    @(negedge clk);
    chk("stray estado", est[0], 0);
    chk("stray ocupado", ocup[0], 0);
    foreach (tab[v]) begin
      fill(tab[v].d, tab[v].rnd);
      run_frame(tab[v].d, tab[v].rnd ? int'($urandom_range(1, 6)) : tab[v].lat, 1'b0, tab[v].nbytes,
                $sformatf("vec%0d", v));
    end
    fill(0, 1'b0);
    run_frame(0, 5, 1'b1, 18, "busy_partida");
    lat[0] = 20;
    bg = got.size();
    @(negedge clk);
    pulse_partida(0);
    for (int t = 0; t < 5000 && got.size() < bg + 5; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort tx_dados", txd[0], 0);
    chk("abort tx_partida", txp[0], 0);
    chk("abort ocupado", ocup[0], 0);
    chk("abort pronto", pr[0], 0);
    chk("abort addr", {al[0], ac[0]}, 0);
    chk("abort estado", est[0], 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bg = got.size();
    repeat (40) @(negedge clk);
    chk("abort silent", got.size() - bg, 0);
    run_frame(0, 20, 1'b0, 18, "after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
